// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for mem_arbiter and its rotating-priority picker rr_pick.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    localparam int unsigned MAX_CHANNELS = 8;

    // Index width that stays at least one bit for a single-channel build.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? unsigned'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after start_i, with wrap.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [IDX_W-1:0] grant_o,
    output logic             any_o
);

    int unsigned idx;

    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(start_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any_o && req_i[IDX_W'(idx)]) begin
                any_o   = 1'b1;
                grant_o = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// N-channel arbiter serialising byte-wide clients onto one sram_ctrl-style port.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin grants; undefined gives fixed lowest-index priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned ADDR_W   = 20,
    parameter int unsigned DATA_W   = 8
) (
    input  logic                         mclk,
    input  logic                         reset,
    input  logic [CHANNELS-1:0]          ch_begin_wr,
    input  logic [CHANNELS-1:0]          ch_begin_rd,
    input  logic [CHANNELS*ADDR_W-1:0]   ch_addr,
    input  logic [CHANNELS*DATA_W-1:0]   ch_data_wr,
    output logic [CHANNELS-1:0]          ch_finish,
    output logic [DATA_W-1:0]            ch_data_rd,
    output logic [CHANNELS-1:0]          ch_overrun,
    output logic                         mem_begin_wr,
    output logic                         mem_begin_rd,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_data_wr,
    input  logic                         mem_finish,
    input  logic [DATA_W-1:0]            mem_data_rd,
    output logic                         busy
);

    localparam int unsigned IDX_W = idx_width(CHANNELS);

    logic [1:0]          state_q, state_d;
    logic [IDX_W-1:0]    g_q, g_d;
    logic [CHANNELS-1:0] pend_valid_q, pend_valid_d;
    logic [CHANNELS-1:0] pend_op_q, pend_op_d;
    logic [ADDR_W-1:0]   pend_addr_q [CHANNELS];
    logic [ADDR_W-1:0]   pend_addr_d [CHANNELS];
    logic [DATA_W-1:0]   pend_data_q [CHANNELS];
    logic [DATA_W-1:0]   pend_data_d [CHANNELS];
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                beg_wr_q, beg_wr_d;
    logic                beg_rd_q, beg_rd_d;
    logic [CHANNELS-1:0] fin_q, fin_d;
    logic [CHANNELS-1:0] ovr_q, ovr_d;
    logic [CHANNELS-1:0] beg, clr, free;
    logic                complete;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic [IDX_W-1:0]    start;

    assign complete = (state_q == ST_WAIT) && mem_finish;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (complete) begin
            rr_ptr_d = (g_q == IDX_W'(CHANNELS - 1)) ? '0 : g_q + 1'b1;
        end
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign start = rr_ptr_q;
`else
    assign start = '0;
`endif

    rr_pick #(
        .N     (CHANNELS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (pend_valid_q),
        .start_i (start),
        .grant_o (pick_idx),
        .any_o   (pick_any)
    );

    // A channel completing at this edge counts as free, so a same-edge begin reloads it.
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_op_d    = pend_op_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        ovr_d        = '0;
        beg          = '0;
        clr          = '0;
        free         = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            beg[i]  = ch_begin_wr[i] | ch_begin_rd[i];
            clr[i]  = complete && (g_q == IDX_W'(i));
            free[i] = !pend_valid_q[i] || clr[i];
            if (clr[i]) begin
                pend_valid_d[i] = 1'b0;
            end
            ovr_d[i] = (beg[i] && !free[i]) || (ch_begin_wr[i] && ch_begin_rd[i]);
            if (beg[i] && free[i]) begin
                pend_valid_d[i] = 1'b1;
                pend_op_d[i]    = ch_begin_wr[i] ? OP_WR : OP_RD;
                pend_addr_d[i]  = ch_addr[i*ADDR_W +: ADDR_W];
                pend_data_d[i]  = ch_data_wr[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        beg_wr_d = 1'b0;
        beg_rd_d = 1'b0;
        fin_d    = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    g_d      = pick_idx;
                    addr_d   = pend_addr_q[pick_idx];
                    wdata_d  = pend_data_q[pick_idx];
                    beg_wr_d = (pend_op_q[pick_idx] == OP_WR);
                    beg_rd_d = (pend_op_q[pick_idx] == OP_RD);
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_finish) begin
                    rdata_d    = mem_data_rd;
                    fin_d[g_q] = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            g_q          <= '0;
            pend_valid_q <= '0;
            pend_op_q    <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                pend_addr_q[i] <= '0;
                pend_data_q[i] <= '0;
            end
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            beg_wr_q <= 1'b0;
            beg_rd_q <= 1'b0;
            fin_q    <= '0;
            ovr_q    <= '0;
        end else begin
            state_q      <= state_d;
            g_q          <= g_d;
            pend_valid_q <= pend_valid_d;
            pend_op_q    <= pend_op_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            beg_wr_q     <= beg_wr_d;
            beg_rd_q     <= beg_rd_d;
            fin_q        <= fin_d;
            ovr_q        <= ovr_d;
        end
    end

    assign ch_finish    = fin_q;
    assign ch_data_rd   = rdata_q;
    assign ch_overrun   = ovr_q;
    assign mem_begin_wr = beg_wr_q;
    assign mem_begin_rd = beg_rd_q;
    assign mem_addr     = addr_q;
    assign mem_data_wr  = wdata_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with three channels and a simple downstream memory model.
module tb_mem_arbiter;

    localparam int C  = 3;
    localparam int AW = 20;
    localparam int DW = 8;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
    } iss_t;

    typedef struct {
        int            ch;
        logic [DW-1:0] d;
    } cmp_t;

    logic            mclk = 1'b0;
    logic            reset = 1'b1;
    logic [C-1:0]    stim_wr = '0, stim_rd = '0, mdl_rd = '0;
    logic [C-1:0]    beg_wr, beg_rd;
    logic [C*AW-1:0] ch_addr = '0;
    logic [C*DW-1:0] ch_data_wr = '0;
    logic [C-1:0]    ch_finish, ch_overrun;
    logic [DW-1:0]   ch_data_rd;
    logic            mem_begin_wr, mem_begin_rd, busy;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_data_wr;
    logic            mdl_fin = 1'b0, stim_fin = 1'b0, mem_finish;
    logic [DW-1:0]   mem_data_rd = '0;

    logic [DW-1:0]   mdl_rdata = '0;
    logic            mdl_auto = 1'b1;
    int              mdl_lat = 3;
    int              rereq_cnt = 0;

    iss_t          iss_q[$];
    cmp_t          exp_q[$];
    int            ovr_cnt[C];
    int            ovr_exp[C];
    logic [AW-1:0] last_addr = '0;
    int            n_tests = 0;
    int            n_fail = 0;

    assign beg_wr     = stim_wr;
    assign beg_rd     = stim_rd | mdl_rd;
    assign mem_finish = mdl_fin | stim_fin;

    always #5 mclk = ~mclk;

    mem_arbiter #(
        .CHANNELS (C),
        .ADDR_W   (AW),
        .DATA_W   (DW)
    ) dut (
        .mclk         (mclk),
        .reset        (reset),
        .ch_begin_wr  (beg_wr),
        .ch_begin_rd  (beg_rd),
        .ch_addr      (ch_addr),
        .ch_data_wr   (ch_data_wr),
        .ch_finish    (ch_finish),
        .ch_data_rd   (ch_data_rd),
        .ch_overrun   (ch_overrun),
        .mem_begin_wr (mem_begin_wr),
        .mem_begin_rd (mem_begin_rd),
        .mem_addr     (mem_addr),
        .mem_data_wr  (mem_data_wr),
        .mem_finish   (mem_finish),
        .mem_data_rd  (mem_data_rd),
        .busy         (busy)
    );

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, got, exp, $time);
        end
    endfunction

    function automatic void bad(input string nm, input logic [31:0] got);
        n_tests++;
        n_fail++;
        $display("FAIL %s: unexpected value 0x%0h at %0t", nm, got, $time);
    endfunction

    // Downstream memory: answer each begin after mdl_lat cycles, optionally re-requesting.
    always begin
        @(negedge mclk);
        if ((mem_begin_wr || mem_begin_rd) && mdl_auto) begin
            repeat (mdl_lat - 1) @(negedge mclk);
            mdl_fin     = 1'b1;
            mem_data_rd = mdl_rdata;
            if (rereq_cnt > 0) begin
                mdl_rd    = C'(1) << (mem_addr - 20'h00100);
                rereq_cnt = rereq_cnt - 1;
            end
            @(negedge mclk);
            mdl_fin = 1'b0;
            mdl_rd  = '0;
        end
    end

    iss_t ie;
    always @(negedge mclk) begin
        if (mem_begin_wr || mem_begin_rd) begin
            if (iss_q.size() == 0) begin
                bad("unexpected_issue", {mem_begin_wr, mem_begin_rd});
            end else begin
                ie = iss_q.pop_front();
                chk("issue_op", {30'd0, mem_begin_wr, mem_begin_rd}, ie.wr ? 32'd2 : 32'd1);
                chk("issue_addr", 32'(mem_addr), 32'(ie.addr));
                if (ie.wr) chk("issue_wdata", 32'(mem_data_wr), 32'(ie.wd));
                last_addr = ie.addr;
            end
        end
        if (mem_finish && busy) begin
            chk("addr_stable", 32'(mem_addr), 32'(last_addr));
        end
    end

    cmp_t ce;
    always @(negedge mclk) begin
        if (ch_finish != '0) begin
            if (exp_q.size() == 0) begin
                bad("unexpected_finish", 32'(ch_finish));
            end else begin
                ce = exp_q.pop_front();
                chk("finish_chan", 32'(ch_finish), 32'(1) << ce.ch);
                chk("finish_data", 32'(ch_data_rd), 32'(ce.d));
            end
        end
        for (int i = 0; i < C; i++) begin
            if (ch_overrun[i]) ovr_cnt[i]++;
        end
    end

    task automatic req(input int ch, input logic wr, input logic rd,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge mclk);
        stim_wr[ch] = wr;
        stim_rd[ch] = rd;
        ch_addr[ch*AW +: AW]    = a;
        ch_data_wr[ch*DW +: DW] = d;
        @(negedge mclk);
        stim_wr = '0;
        stim_rd = '0;
    endtask

    task automatic push(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input int ch, input logic [DW-1:0] rd);
        iss_q.push_back('{wr: wr, addr: a, wd: wd});
        exp_q.push_back('{ch: ch, d: rd});
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge mclk);
            n++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge mclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        int order[6] = '{0, 1, 2, 0, 1, 2};
`else
        int order[6] = '{0, 0, 0, 0, 1, 2};
`endif
        for (int i = 0; i < C; i++) begin
            ovr_cnt[i] = 0;
            ovr_exp[i] = 0;
        end

        repeat (3) @(negedge mclk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_finish", 32'(ch_finish), 32'd0);
        chk("rst_begin", {30'd0, mem_begin_wr, mem_begin_rd}, 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_rdata", 32'(ch_data_rd), 32'd0);
        chk("rst_overrun", 32'(ch_overrun), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge mclk);

        // Single read with begin latency checks.
        mdl_rdata = 8'hA5;
        push(1'b0, 20'h00123, 8'h00, 0, 8'hA5);
        req(0, 1'b0, 1'b1, 20'h00123, 8'h00);
        chk("rd_idle_after_k", 32'(busy), 32'd0);
        @(posedge mclk); #1;
        chk("rd_begin_k1", 32'(mem_begin_rd), 32'd1);
        @(posedge mclk); #1;
        chk("rd_begin_k2", 32'(mem_begin_rd), 32'd0);
        drain(50);

        // Write pass-through; read data is captured on writes too.
        mdl_rdata = 8'h77;
        push(1'b1, 20'h0FFFF, 8'h3C, 1, 8'h77);
        req(1, 1'b1, 1'b0, 20'h0FFFF, 8'h3C);
        drain(50);

        // Overrun while pending, then simultaneous wr+rd.
        mdl_rdata = 8'h42;
        push(1'b0, 20'h00200, 8'h00, 0, 8'h42);
        req(0, 1'b0, 1'b1, 20'h00200, 8'h00);
        req(0, 1'b0, 1'b1, 20'h00300, 8'h00);
        ovr_exp[0]++;
        drain(50);
        mdl_rdata = 8'h19;
        push(1'b1, 20'h00400, 8'h11, 2, 8'h19);
        req(2, 1'b1, 1'b1, 20'h00400, 8'h11);
        ovr_exp[2]++;
        drain(50);

        // Contention: each completion re-requests on the finish edge.
        mdl_rdata = 8'h5C;
        for (int i = 0; i < 6; i++) begin
            push(1'b0, 20'h00100 + 20'(order[i]), 8'h00, order[i], 8'h5C);
        end
        @(negedge mclk);
        for (int i = 0; i < C; i++) ch_addr[i*AW +: AW] = 20'h00100 + 20'(i);
        rereq_cnt = 3;
        stim_rd = 3'b111;
        @(negedge mclk);
        stim_rd = '0;
        drain(200);

        // Reset while waiting on the downstream, then a late finish.
        mdl_auto = 1'b0;
        iss_q.push_back('{wr: 1'b0, addr: 20'h00500, wd: 8'h00});
        req(1, 1'b0, 1'b1, 20'h00500, 8'h00);
        repeat (3) @(negedge mclk);
        chk("wait_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_wait_busy", 32'(busy), 32'd0);
        chk("rst_wait_begin", {30'd0, mem_begin_wr, mem_begin_rd}, 32'd0);
        @(negedge mclk);
        reset = 1'b0;
        mdl_auto = 1'b1;
        stim_fin = 1'b1;
        @(negedge mclk);
        stim_fin = 1'b0;
        repeat (4) @(negedge mclk);
        chk("late_fin_busy", 32'(busy), 32'd0);
        mdl_rdata = 8'h6E;
        push(1'b0, 20'h00600, 8'h00, 1, 8'h6E);
        req(1, 1'b0, 1'b1, 20'h00600, 8'h00);
        drain(50);

        // Stray finish while idle.
        stim_fin = 1'b1;
        @(negedge mclk);
        stim_fin = 1'b0;
        chk("stray_busy", 32'(busy), 32'd0);
        chk("stray_finish", 32'(ch_finish), 32'd0);
        repeat (3) @(negedge mclk);
        chk("stray_busy_later", 32'(busy), 32'd0);

        chk("issue_queue_empty", 32'(iss_q.size()), 32'd0);
        for (int i = 0; i < C; i++) begin
            chk($sformatf("overrun_count_%0d", i), 32'(ovr_cnt[i]), 32'(ovr_exp[i]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
